// File: rtl/pop_multiple_sequencer_pkg.sv
// Shared types, register numbers and state encoding for the POP {reglist[, PC]} sequencer.
// The helper is_active marks the states that hold the pipeline off the write port.
package pop_multiple_sequencer_pkg;

   typedef logic reg_file_write_sig;
   typedef logic branch_from_wb;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      SP_WB  = 3'd2,
      BRANCH = 3'd3,
      DONE   = 3'd4
   } pop_seq_state_e;

   localparam int REG_SP         = 13;
   localparam int REG_PC         = 15;
   localparam int POP_LIST_WIDTH = 9;

   function automatic logic is_active(input pop_seq_state_e s);
      return (s == READ) || (s == SP_WB) || (s == BRANCH);
   endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit of a list, plus a valid flag.
module lowest_set_bit_encoder #(
   parameter int WIDTH = 9,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] bits,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan from the top so the lowest set bit is the last one to assign idx.
   always_comb begin
      idx   = '0;
      valid = |bits;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (bits[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/pop_multiple_sequencer.sv
// Multi-cycle Thumb POP sequencer beside write-back: one read per listed register, optional SP
// write-back (enabled by macro POP_SEQ_SP_WRITEBACK_EN), and a write-back branch when PC is popped.
module pop_multiple_sequencer
   import pop_multiple_sequencer_pkg::*;
#(
   parameter int WORD       = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int LIST_WIDTH = POP_LIST_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [LIST_WIDTH-1:0] reg_list_i,
   input  logic [WORD-1:0]       base_addr_i,
   output logic                  mem_req_o,
   output logic [WORD-1:0]       mem_addr_o,
   input  logic                  mem_ack_i,
   input  logic [WORD-1:0]       mem_rdata_i,
   output reg_file_write_sig     reg_file_write_en_o,
   output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
   output logic [WORD-1:0]       reg_data_o,
   output branch_from_wb         branch_from_wb_o,
   output logic [WORD-1:0]       program_counter_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int IDX_W = $clog2(LIST_WIDTH);
   localparam logic [IDX_W-1:0] PC_BIT = IDX_W'(LIST_WIDTH - 1);

   pop_seq_state_e        state_reg, state_next;
   logic [LIST_WIDTH-1:0] list_reg, list_next;
   logic [WORD-1:0]       addr_reg, addr_next;
   logic [WORD-1:0]       pc_reg, pc_next;
   logic                  pc_listed_reg, pc_listed_next;

   logic [IDX_W-1:0]      low_idx;
   logic                  low_valid;

   logic                  req_next;
   logic [WORD-1:0]       mem_addr_next;
   logic                  wr_en_next;
   logic [ADDR_WIDTH-1:0] dest_next;
   logic [WORD-1:0]       data_next;
   logic                  branch_next;
   logic [WORD-1:0]       target_next;
   logic                  busy_next;
   logic                  done_next;

   lowest_set_bit_encoder #(
      .WIDTH (LIST_WIDTH),
      .IDX_W (IDX_W)
   ) u_low_bit (
      .bits  (list_reg),
      .idx   (low_idx),
      .valid (low_valid)
   );

`ifdef POP_SEQ_SP_WRITEBACK_EN
   localparam int CNT_W = $clog2(LIST_WIDTH + 1);

   logic [WORD-1:0]  base_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WORD-1:0]  sp_value;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         base_reg <= '0;
         cnt_reg  <= '0;
      end else if (state_reg == IDLE && start_i && (|reg_list_i)) begin
         base_reg <= base_addr_i;
         cnt_reg  <= '0;
      end else if (state_reg == READ && mem_ack_i) begin
         cnt_reg  <= cnt_reg + CNT_W'(1);
      end
   end

   assign sp_value = base_reg + (WORD'(cnt_reg) << 2);
`endif

   always_comb begin
      state_next     = state_reg;
      list_next      = list_reg;
      addr_next      = addr_reg;
      pc_next        = pc_reg;
      pc_listed_next = pc_listed_reg;
      wr_en_next     = 1'b0;
      dest_next      = '0;
      data_next      = '0;
      branch_next    = 1'b0;
      target_next    = '0;
      done_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_i) begin
               if (|reg_list_i) begin
                  list_next      = reg_list_i;
                  addr_next      = base_addr_i;
                  pc_listed_next = reg_list_i[LIST_WIDTH-1];
                  pc_next        = '0;
                  state_next     = READ;
               end else begin
                  state_next = DONE;
               end
            end
         end
         READ: begin
            if (mem_ack_i && low_valid) begin
               // Clearing the lowest set bit advances to the next register in ascending order.
               list_next = list_reg & (list_reg - LIST_WIDTH'(1));
               addr_next = addr_reg + WORD'(4);
               if (low_idx != PC_BIT) begin
                  wr_en_next = 1'b1;
                  dest_next  = ADDR_WIDTH'(low_idx);
                  data_next  = mem_rdata_i;
               end else begin
                  pc_next = mem_rdata_i;
               end
               if (list_next == '0) begin
`ifdef POP_SEQ_SP_WRITEBACK_EN
                  state_next = SP_WB;
`else
                  state_next = pc_listed_reg ? BRANCH : DONE;
`endif
               end
            end
         end
`ifdef POP_SEQ_SP_WRITEBACK_EN
         SP_WB: begin
            wr_en_next = 1'b1;
            dest_next  = ADDR_WIDTH'(REG_SP);
            data_next  = sp_value;
            state_next = pc_listed_reg ? BRANCH : DONE;
         end
`endif
         BRANCH: begin
            branch_next = 1'b1;
            target_next = pc_reg;
            state_next  = DONE;
         end
         DONE: begin
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Request leads the state so the read is on the bus in the first READ cycle.
      req_next      = (state_next == READ);
      mem_addr_next = req_next ? addr_next : '0;
      busy_next     = is_active(state_reg) || is_active(state_next);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_reg           <= IDLE;
         list_reg            <= '0;
         addr_reg            <= '0;
         pc_reg              <= '0;
         pc_listed_reg       <= 1'b0;
         mem_req_o           <= 1'b0;
         mem_addr_o          <= '0;
         reg_file_write_en_o <= 1'b0;
         reg_dest_addr_o     <= '0;
         reg_data_o          <= '0;
         branch_from_wb_o    <= 1'b0;
         program_counter_o   <= '0;
         busy_o              <= 1'b0;
         done_o              <= 1'b0;
      end else begin
         state_reg           <= state_next;
         list_reg            <= list_next;
         addr_reg            <= addr_next;
         pc_reg              <= pc_next;
         pc_listed_reg       <= pc_listed_next;
         mem_req_o           <= req_next;
         mem_addr_o          <= mem_addr_next;
         reg_file_write_en_o <= wr_en_next;
         reg_dest_addr_o     <= dest_next;
         reg_data_o          <= data_next;
         branch_from_wb_o    <= branch_next;
         program_counter_o   <= target_next;
         busy_o              <= busy_next;
         done_o              <= done_next;
      end
   end

endmodule

// File: tb/tb_pop_multiple_sequencer.sv
// Directed self-checking bench for pop_multiple_sequencer; expectations adapt to POP_SEQ_SP_WRITEBACK_EN.
// Cycle 1 is the cycle right after the edge that accepts start_i.
module tb_pop_multiple_sequencer;
   import pop_multiple_sequencer_pkg::*;

`ifdef POP_SEQ_SP_WRITEBACK_EN
   localparam int SPW = 1;
`else
   localparam int SPW = 0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_n_i;
   logic              start_i;
   logic [8:0]        reg_list_i;
   logic [31:0]       base_addr_i;
   logic              mem_req_o;
   logic [31:0]       mem_addr_o;
   logic              mem_ack_i;
   logic [31:0]       mem_rdata_i;
   reg_file_write_sig reg_file_write_en_o;
   logic [3:0]        reg_dest_addr_o;
   logic [31:0]       reg_data_o;
   branch_from_wb     branch_from_wb_o;
   logic [31:0]       program_counter_o;
   logic              busy_o;
   logic              done_o;

   always #5 clk_i = ~clk_i;

   pop_multiple_sequencer dut (
      .clk_i               (clk_i),
      .rst_n_i             (rst_n_i),
      .start_i             (start_i),
      .reg_list_i          (reg_list_i),
      .base_addr_i         (base_addr_i),
      .mem_req_o           (mem_req_o),
      .mem_addr_o          (mem_addr_o),
      .mem_ack_i           (mem_ack_i),
      .mem_rdata_i         (mem_rdata_i),
      .reg_file_write_en_o (reg_file_write_en_o),
      .reg_dest_addr_o     (reg_dest_addr_o),
      .reg_data_o          (reg_data_o),
      .branch_from_wb_o    (branch_from_wb_o),
      .program_counter_o   (program_counter_o),
      .busy_o              (busy_o),
      .done_o              (done_o)
   );

   int checks = 0;
   int errors = 0;

   // Per-operation observation log, filled by run_op.
   int          n_wr, n_rd, n_br, n_done, done_cyc, br_cyc, addr_moves, req_cycles, busy_cycles;
   logic [3:0]  wr_dest [32];
   logic [31:0] wr_data [32];
   int          wr_cyc  [32];
   logic [31:0] rd_addr [16];
   logic [31:0] br_pc;
   logic        busy_at [64];
   logic [31:0] tab     [8];
   int          sp_count, sp_cyc;
   logic [31:0] sp_data;

   task automatic run_op(input logic [8:0] list, input logic [31:0] base, input int hold,
                         input int stray_cyc, input int max_cyc);
      int          waitc;
      int          rdi;
      logic        prev_wait;
      logic [31:0] prev_addr;
      n_wr = 0; n_br = 0; n_done = 0; done_cyc = -1; br_cyc = -1; addr_moves = 0;
      req_cycles = 0; busy_cycles = 0; br_pc = '0;
      waitc = 0; rdi = 0; prev_wait = 1'b0; prev_addr = '0;
      start_i = 1'b1; reg_list_i = list; base_addr_i = base;
      @(posedge clk_i); #1;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         busy_at[cyc] = busy_o;
         if (busy_o) busy_cycles++;
         if (mem_req_o) req_cycles++;
         if (reg_file_write_en_o && n_wr < 32) begin
            wr_dest[n_wr] = reg_dest_addr_o; wr_data[n_wr] = reg_data_o; wr_cyc[n_wr] = cyc;
            n_wr++;
         end
         if (branch_from_wb_o) begin n_br++; br_pc = program_counter_o; br_cyc = cyc; end
         if (done_o) begin n_done++; done_cyc = cyc; end
         if (prev_wait && (mem_addr_o !== prev_addr || mem_req_o !== 1'b1)) addr_moves++;
         start_i     = (cyc == stray_cyc);
         reg_list_i  = start_i ? 9'h0FF : 9'h000;
         base_addr_i = start_i ? 32'hDEAD_0000 : 32'h0;
         if (mem_req_o && waitc >= hold) begin
            mem_ack_i = 1'b1; mem_rdata_i = tab[rdi % 8];
            if (rdi < 16) rd_addr[rdi] = mem_addr_o;
            rdi++; waitc = 0; prev_wait = 1'b0;
         end else begin
            mem_ack_i = 1'b0; mem_rdata_i = '0;
            prev_wait = mem_req_o; prev_addr = mem_addr_o;
            if (mem_req_o) waitc++;
         end
         @(posedge clk_i); #1;
      end
      n_rd = rdi;
      mem_ack_i = 1'b0; mem_rdata_i = '0; start_i = 1'b0; reg_list_i = '0; base_addr_i = '0;
      sp_count = 0; sp_cyc = -1; sp_data = '0;
      for (int i = 0; i < n_wr; i++) begin
         if (wr_dest[i] == 4'd13) begin sp_count++; sp_data = wr_data[i]; sp_cyc = wr_cyc[i]; end
      end
      $display("op list=%03h base=%08h reads=%0d writes=%0d branches=%0d done_at=%0d",
               list, base, n_rd, n_wr, n_br, done_cyc);
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; start_i = 1'b0; reg_list_i = '0; base_addr_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if ({mem_req_o, mem_addr_o, reg_file_write_en_o, reg_dest_addr_o, reg_data_o,
           branch_from_wb_o, program_counter_o, busy_o, done_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b addr=%h we=%b busy=%b done=%b want all zero",
                  mem_req_o, mem_addr_o, reg_file_write_en_o, busy_o, done_o);
      end
      checks++;
      if (dut.state_reg !== IDLE) begin
         errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_reg, IDLE);
      end
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      $display("reset released");
   endtask

   task automatic test_three_regs();
      tab[0] = 32'hA; tab[1] = 32'hB; tab[2] = 32'hC;
      run_op(9'h007, 32'h0000_1000, 0, 0, 10);
      checks++;
      if (n_wr !== 3 + SPW) begin errors++; $display("FAIL three_write_count: got %0d want %0d", n_wr, 3 + SPW); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wr_dest[i] !== 4'(i) || wr_data[i] !== tab[i] || wr_cyc[i] !== 2 + i) begin
            errors++;
            $display("FAIL three_write_%0d: got r%0d=%h at %0d want r%0d=%h at %0d",
                     i, wr_dest[i], wr_data[i], wr_cyc[i], i, tab[i], 2 + i);
         end
         checks++;
         if (rd_addr[i] !== 32'h1000 + 32'(4 * i)) begin
            errors++; $display("FAIL three_read_addr_%0d: got %h want %h", i, rd_addr[i], 32'h1000 + 32'(4 * i));
         end
      end
      checks++;
      if (sp_count !== SPW) begin errors++; $display("FAIL three_sp_count: got %0d want %0d", sp_count, SPW); end
      if (sp_count > 0) begin
         checks++;
         if (sp_data !== 32'h100C || sp_cyc !== 5) begin
            errors++; $display("FAIL three_sp_value: got %h at %0d want 0000100c at 5", sp_data, sp_cyc);
         end
      end
      checks++;
      if (n_br !== 0 || n_done !== 1 || done_cyc !== 5 + SPW) begin
         errors++; $display("FAIL three_done: got branches=%0d done=%0d at %0d want 0, 1 at %0d",
                            n_br, n_done, done_cyc, 5 + SPW);
      end
      checks++;
      if (busy_at[1] !== 1'b1 || (done_cyc > 0 && busy_at[done_cyc] !== 1'b0)) begin
         errors++; $display("FAIL three_busy: got first=%b at_done=%b want 1 0", busy_at[1],
                            (done_cyc > 0) ? busy_at[done_cyc] : 1'bx);
      end
   endtask

   task automatic test_pc_listed();
      tab[0] = 32'h55; tab[1] = 32'h8000_0041;
      run_op(9'h110, 32'h0000_2000, 0, 0, 10);
      checks++;
      if (n_wr !== 1 + SPW || wr_dest[0] !== 4'd4 || wr_data[0] !== 32'h55 || wr_cyc[0] !== 2) begin
         errors++; $display("FAIL pc_r4_write: got n=%0d r%0d=%h at %0d want n=%0d r4=00000055 at 2",
                            n_wr, wr_dest[0], wr_data[0], wr_cyc[0], 1 + SPW);
      end
      checks++;
      if (n_rd !== 2 || rd_addr[0] !== 32'h2000 || rd_addr[1] !== 32'h2004) begin
         errors++; $display("FAIL pc_reads: got n=%0d %h %h want 2 00002000 00002004", n_rd, rd_addr[0], rd_addr[1]);
      end
      checks++;
      if (sp_count !== SPW) begin errors++; $display("FAIL pc_sp_count: got %0d want %0d", sp_count, SPW); end
      if (sp_count > 0) begin
         checks++;
         if (sp_data !== 32'h2008) begin errors++; $display("FAIL pc_sp_value: got %h want 00002008", sp_data); end
      end
      checks++;
      if (n_br !== 1 || br_pc !== 32'h8000_0041 || br_cyc !== 4 + SPW) begin
         errors++; $display("FAIL pc_branch: got n=%0d pc=%h at %0d want 1 80000041 at %0d",
                            n_br, br_pc, br_cyc, 4 + SPW);
      end
      checks++;
      if (br_cyc > 0 && busy_at[br_cyc] !== 1'b1) begin
         errors++; $display("FAIL pc_busy_branch: got %b want 1", busy_at[br_cyc]);
      end
      checks++;
      if (n_done !== 1 || done_cyc !== 5 + SPW) begin
         errors++; $display("FAIL pc_done: got n=%0d at %0d want 1 at %0d", n_done, done_cyc, 5 + SPW);
      end
   endtask

   task automatic test_wait_states();
      tab[0] = 32'h0000_0077;
      run_op(9'h080, 32'h0000_3000, 5, 3, 14);
      checks++;
      if (addr_moves !== 0) begin errors++; $display("FAIL wait_addr_stable: got %0d changes want 0", addr_moves); end
      checks++;
      if (n_rd !== 1 || rd_addr[0] !== 32'h3000 || req_cycles !== 6) begin
         errors++; $display("FAIL wait_reads: got n=%0d addr=%h req_cycles=%0d want 1 00003000 6",
                            n_rd, rd_addr[0], req_cycles);
      end
      checks++;
      if (n_wr !== 1 + SPW || wr_dest[0] !== 4'd7 || wr_data[0] !== 32'h77 || wr_cyc[0] !== 7) begin
         errors++; $display("FAIL wait_r7_write: got n=%0d r%0d=%h at %0d want n=%0d r7=00000077 at 7",
                            n_wr, wr_dest[0], wr_data[0], wr_cyc[0], 1 + SPW);
      end
      if (sp_count > 0) begin
         checks++;
         if (sp_data !== 32'h3004) begin errors++; $display("FAIL wait_sp_value: got %h want 00003004", sp_data); end
      end
      checks++;
      if (n_done !== 1 || done_cyc !== 8 + SPW || n_br !== 0) begin
         errors++; $display("FAIL wait_done: got n=%0d at %0d br=%0d want 1 at %0d br=0",
                            n_done, done_cyc, n_br, 8 + SPW);
      end
   endtask

   task automatic test_empty_list();
      run_op(9'h000, 32'h0000_4000, 0, 0, 6);
      checks++;
      if (n_done !== 1 || done_cyc !== 2) begin
         errors++; $display("FAIL empty_done: got n=%0d at %0d want 1 at 2", n_done, done_cyc);
      end
      checks++;
      if (req_cycles !== 0 || n_wr !== 0 || n_br !== 0 || busy_cycles !== 0) begin
         errors++; $display("FAIL empty_quiet: got req=%0d writes=%0d br=%0d busy=%0d want all 0",
                            req_cycles, n_wr, n_br, busy_cycles);
      end
   endtask

   task automatic test_reset_mid_op();
      logic any_activity;
      start_i = 1'b1; reg_list_i = 9'h007; base_addr_i = 32'h0000_5000;
      @(posedge clk_i); #1;
      start_i = 1'b0; reg_list_i = '0; base_addr_i = '0;
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h5000) begin
         errors++; $display("FAIL midrst_first_req: got req=%b addr=%h want 1 00005000", mem_req_o, mem_addr_o);
      end
      mem_ack_i = 1'b1; mem_rdata_i = 32'h11;
      @(posedge clk_i); #1;
      checks++;
      if (reg_file_write_en_o !== 1'b1 || reg_dest_addr_o !== 4'd0 || reg_data_o !== 32'h11) begin
         errors++; $display("FAIL midrst_r0_write: got we=%b r%0d=%h want 1 r0=00000011",
                            reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
      end
      mem_ack_i = 1'b0; mem_rdata_i = '0; rst_n_i = 1'b0;
      @(posedge clk_i); #1;
      checks++;
      if ({mem_req_o, mem_addr_o, reg_file_write_en_o, reg_dest_addr_o, reg_data_o,
           branch_from_wb_o, program_counter_o, busy_o, done_o} !== '0 || dut.state_reg !== IDLE) begin
         errors++; $display("FAIL midrst_outputs: got req=%b we=%b busy=%b done=%b state=%0d want zeros, IDLE",
                            mem_req_o, reg_file_write_en_o, busy_o, done_o, dut.state_reg);
      end
      rst_n_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD;
      any_activity = 1'b0;
      repeat (6) begin
         @(posedge clk_i); #1;
         any_activity |= mem_req_o | reg_file_write_en_o | branch_from_wb_o | done_o | busy_o;
      end
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      checks++;
      if (any_activity !== 1'b0) begin
         errors++; $display("FAIL midrst_quiet: got activity=%b want 0", any_activity);
      end
      $display("op reset mid-operation list=007 base=00005000");
   endtask

   task automatic test_addr_wrap();
      tab[0] = 32'h1; tab[1] = 32'h2;
      run_op(9'h003, 32'hFFFF_FFFC, 0, 0, 10);
      checks++;
      if (n_rd !== 2 || rd_addr[0] !== 32'hFFFF_FFFC || rd_addr[1] !== 32'h0) begin
         errors++; $display("FAIL wrap_reads: got n=%0d %h %h want 2 fffffffc 00000000", n_rd, rd_addr[0], rd_addr[1]);
      end
      checks++;
      if (wr_dest[1] !== 4'd1 || wr_data[1] !== 32'h2 || wr_cyc[1] !== 3) begin
         errors++; $display("FAIL wrap_r1_write: got r%0d=%h at %0d want r1=00000002 at 3",
                            wr_dest[1], wr_data[1], wr_cyc[1]);
      end
      checks++;
      if (sp_count !== SPW) begin errors++; $display("FAIL wrap_sp_count: got %0d want %0d", sp_count, SPW); end
      if (sp_count > 0) begin
         checks++;
         if (sp_data !== 32'h4) begin errors++; $display("FAIL wrap_sp_value: got %h want 00000004", sp_data); end
      end
   endtask

   initial begin
      test_reset();
      test_three_regs();
      test_pc_listed();
      test_wait_states();
      test_empty_list();
      test_reset_mid_op();
      test_addr_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
